// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter:
// parity modes, framing FSM states and a counter width helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int width_for(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// Pushes are ignored when full, pops are ignored when empty.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [width_for(DEPTH+1)-1:0] count
);

  localparam int AW = width_for(DEPTH);
  localparam int CW = width_for(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; no reset needed since occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: queues words in a FIFO and sends them
// LSB-first with optional parity and one or two stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              send,
  output logic              ready,
  output logic              tx,
  output logic              tx_busy,
  output logic              overflow
);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_fifo: DATA_W must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  localparam int BAUD_W = width_for(CLKS_PER_BIT);
  localparam int BIT_W  = width_for(DATA_W + 1);
  localparam int CNT_W  = width_for(FIFO_DEPTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              ODD_FLIP  = (PARITY == PAR_ODD);
  localparam logic              HAS_PAR   = (PARITY != PAR_NONE);

  tx_state_e         state, state_n;
  logic [BAUD_W-1:0] baud, baud_n;
  logic [BIT_W-1:0]  bit_cnt, bit_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic              par_bit, par_n;
  logic              tx_n;
  logic              busy_n;
  logic              pop;
  logic              load;
  logic              push_ok;
  logic [DATA_W-1:0] fifo_dout;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  cnt_after;

  uart_sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (send),
    .push_data(data_in),
    .pop      (pop),
    .pop_data (fifo_dout),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign ready   = ~full;
  assign push_ok = send & ~full;

  // Framing next-state logic; load covers both the IDLE pop and the
  // back-to-back pop at the end of the last stop bit.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_cnt;
    shift_n = shift;
    par_n   = par_bit;
    tx_n    = tx;
    load    = 1'b0;

    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) load = 1'b1;
      end
      START: begin
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
          tx_n    = shift[0];
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (bit_cnt == DATA_LAST) begin
            bit_n = '0;
            if (HAS_PAR) begin
              state_n = PAR;
              tx_n    = par_bit;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_n   = bit_cnt + 1'b1;
            shift_n = {1'b0, shift[DATA_W-1:1]};
            tx_n    = shift[1];
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      PAR: begin
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = STOP;
          tx_n    = 1'b1;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (bit_cnt == STOP_LAST) begin
            if (!empty) begin
              load = 1'b1;
            end else begin
              state_n = IDLE;
              tx_n    = 1'b1;
            end
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase

    if (load) begin
      shift_n = fifo_dout;
      par_n   = (^fifo_dout) ^ ODD_FLIP;
      baud_n  = '0;
      state_n = START;
      tx_n    = 1'b0;
    end

    pop = load;
  end

  // Occupancy after this edge, so tx_busy can be registered without lag.
  always_comb begin
    cnt_after = count + CNT_W'(push_ok) - CNT_W'(pop);
    busy_n    = (state_n != IDLE) || (cnt_after != '0);
  end

  // Framing state, counters and registered line outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      par_bit  <= par_n;
      tx       <= tx_n;
      tx_busy  <= busy_n;
      overflow <= send & full;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, the next generation of the fixed 8N1 Uart_protocol transmitter. It buffers words in an internal FIFO and serialises them LSB-first on tx. Data width, parity mode, stop-bit count and baud divisor are configurable. It sits between the host-side send/data_in producer and the serial pin, and adds back-to-back framing and overflow reporting.

Parameters:
DATA_W, 8, data bits per frame; legal 5..9
CLKS_PER_BIT, 868, clk cycles per serial bit; legal >=2
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame; legal 1 or 2
FIFO_DEPTH, 4, word entries; power of 2, >=2

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
data_in  in  DATA_W  word to transmit; sampled when send=1
send  in  1  write strobe; one word accepted per cycle when ready=1
ready  out  1  high when FIFO not full (combinational from registered count)
tx  out  1  serial line, registered, idle high
tx_busy  out  1  high when FSM not IDLE or FIFO not empty
overflow  out  1  one-cycle pulse when send=1 while ready=0; that word is dropped

Behaviour:
- Reset (reset=0, asynchronous): tx=1, tx_busy=0, overflow=0, ready=1, FIFO emptied, FSM=IDLE, bit/baud counters=0. Effective immediately, including mid-frame; the partial frame is abandoned.
- FIFO write: at the rising edge where send=1 and ready=1, data_in is pushed.
  - The write is rejected when full, even if a pop occurs in the same cycle.
  - A simultaneous push and pop when not full leaves the count unchanged.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: tx=1. If FIFO not empty: pop into the shift register, go to START, tx<=0.
  - Latency: a word pushed at edge k into an empty FIFO with FSM in IDLE drives tx low after edge k+1.
  - START: hold for CLKS_PER_BIT cycles, then go to DATA with tx<=shift[0].
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first, for DATA_W bits. Then go to PAR if PARITY!=0, else STOP.
  - PAR: tx = XOR of the data bits (even) or its inverse (odd), held for CLKS_PER_BIT cycles.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end:
    - if the FIFO is not empty, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Frame length is exactly (1 + DATA_W + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary; width is clog2(CLKS_PER_BIT).
- Bit counter width is clog2(DATA_W+1); it resets on entry to DATA.
- tx_busy is registered:
  - rises the cycle after the first push;
  - falls in the same cycle the FSM returns to IDLE with the FIFO empty.
- The data_in value is captured at push; later changes to data_in do not affect queued words.
- Illegal parameter values: elaboration-time error via generate-if $error.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants PAR_NONE / PAR_EVEN / PAR_ODD;
  - the FSM state enum (IDLE, START, DATA, PAR, STOP);
  - a clog2-based width helper function.
- Sub-module uart_sync_fifo: parametrised width/depth, push/pop/full/empty/count, async active-low reset. uart_tx_fifo instantiates it and contains only the framing FSM and counters.

Test Plan:
1. DATA_W=8, PARITY=0, STOP_BITS=1, CLKS_PER_BIT=4: push 8'hA5 once.
   -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
   -> tx_busy high for exactly 40 cycles of framing, then 0.
2. Same configuration with PARITY=1 (even), then PARITY=2 (odd): push 8'hA5.
   -> parity bit 0 for even, 1 for odd; 11-bit frame, 44 cycles.
3. FIFO_DEPTH=4, CLKS_PER_BIT=4: push 8'h01..8'h05 on 5 consecutive cycles.
   -> first pushed word pops the cycle after its push.
   -> 8'h02..8'h05 fill the FIFO, so ready falls after the fifth push and no overflow pulse occurs.
   -> a sixth send while full produces a one-cycle overflow pulse and that word is never transmitted.
   -> the 5 accepted frames go out back-to-back with no idle cycle between stop and start.
4. STOP_BITS=2, DATA_W=7: push 7'h55.
   -> frame is 1+7+2 bits = 40 cycles; stop level held high for 8 cycles.
5. Reset mid-DATA of frame 1 with 2 words queued.
   -> tx=1 and tx_busy=0 asynchronously; FIFO empty, ready=1.
   -> no further tx activity after reset release until a new send.
6. Simultaneous send and internal pop with the FIFO holding 2 words.
   -> count stays 2; word order preserved on tx.
